// File: rtl/seq_pkg.sv
// Shared encodings and default sizes for the serial pattern link
// (generator and detector FSMs).
package seq_pkg;

  localparam int PAT_W_DEF = 6;
  localparam int LEN_W_DEF = 3;
  localparam int CNT_W_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEND = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/seq_shift_ctr.sv
// Bit-index / repetition down-counter pair for the pattern generator.
// Reports when the current bit is the last one of the last repetition.
module seq_shift_ctr #(
  parameter int LEN_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_adv,
  input  logic [LEN_W-1:0] i_len_m1,
  input  logic [CNT_W-1:0] i_rep_m1,
  output logic [LEN_W-1:0] o_idx,
  output logic             o_last_bit,
  output logic             o_last_rep
);

  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] r_len_m1;
  logic [CNT_W-1:0] r_rep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_len_m1 <= '0;
      r_rep    <= '0;
    end else if (i_load) begin
      r_idx    <= i_len_m1;
      r_len_m1 <= i_len_m1;
      r_rep    <= i_rep_m1;
    end else if (i_adv) begin
      if (r_idx != '0) begin
        r_idx <= r_idx - 1'b1;
      end else if (r_rep != '0) begin
        // wrap straight into the next repetition
        r_idx <= r_len_m1;
        r_rep <= r_rep - 1'b1;
      end
    end
  end

  assign o_idx      = r_idx;
  assign o_last_bit = (r_idx == '0);
  assign o_last_rep = (r_rep == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial test-pattern transmitter: sends a latched pattern MSB-first,
// one bit per step pulse, repeated back-to-back.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             system_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             step,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [CNT_W-1:0] repeat_in,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       Q
);

  logic [1:0]       r_state;
  logic [PAT_W-1:0] r_pat;
  logic             r_x_out;
  logic             r_x_valid;
  logic             r_busy;
  logic             r_done;

  logic [LEN_W-1:0] w_len_m1;
  logic [CNT_W-1:0] w_rep_m1;
  logic [LEN_W-1:0] w_idx;
  logic             w_last_bit;
  logic             w_last_rep;
  logic             w_load;
  logic             w_adv;
  logic             w_bit;

  // zero or oversize length means "full pattern register"
  always_comb begin
    w_len_m1 = len_in - 1'b1;
    if (len_in == '0 || len_in > LEN_W'(PAT_W))
      w_len_m1 = LEN_W'(PAT_W - 1);
  end

  assign w_rep_m1 = (repeat_in == '0) ? '0 : repeat_in - 1'b1;
  assign w_load   = (r_state == ST_IDLE) && start;
  assign w_adv    = (r_state == ST_SEND) && step && !abort;
  assign w_bit    = r_pat[w_idx];

  seq_shift_ctr #(
    .LEN_W(LEN_W),
    .CNT_W(CNT_W)
  ) u_ctr (
    .clk       (system_clk),
    .rst       (reset),
    .i_load    (w_load),
    .i_adv     (w_adv),
    .i_len_m1  (w_len_m1),
    .i_rep_m1  (w_rep_m1),
    .o_idx     (w_idx),
    .o_last_bit(w_last_bit),
    .o_last_rep(w_last_rep)
  );

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pat     <= '0;
      r_x_out   <= 1'b0;
      r_x_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_x_valid <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pat   <= pattern_in;
            r_state <= ST_SEND;
            r_busy  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (step) begin
            r_x_out   <= w_bit;
            r_x_valid <= 1'b1;
            if (w_last_bit && w_last_rep) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_x_out <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign x_out   = r_x_out;
  assign x_valid = r_x_valid;
  assign busy    = r_busy;
  assign done    = r_done;
  assign Q       = r_state;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen with an expected-bit scoreboard.
// Expected bits are queued at start and checked on every x_valid.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       step;
  logic [5:0] pattern_in;
  logic [2:0] len_in;
  logic [3:0] repeat_in;
  logic       x_out;
  logic       x_valid;
  logic       busy;
  logic       done;
  logic [1:0] Q;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int d0;
  bit q[$];
  bit last_bit = 1'b0;

  always #5 clk = ~clk;

  seq_pattern_gen dut (
    .system_clk(clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .step      (step),
    .pattern_in(pattern_in),
    .len_in    (len_in),
    .repeat_in (repeat_in),
    .x_out     (x_out),
    .x_valid   (x_valid),
    .busy      (busy),
    .done      (done),
    .Q         (Q)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (x_valid === 1'b1) begin
      chk("sb_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        last_bit = q.pop_front();
        chk("sb_bit", x_out, last_bit);
      end
    end
  end

  task automatic push_exp(input logic [5:0] p, input logic [2:0] l,
                          input logic [3:0] r);
    int el;
    int er;
    el = (l == 0 || l > 6) ? 6 : int'(l);
    er = (r == 0) ? 1 : int'(r);
    for (int k = 0; k < er; k++)
      for (int i = el - 1; i >= 0; i--)
        q.push_back(p[i]);
  endtask

  task automatic start_pat(input logic [5:0] p, input logic [2:0] l,
                           input logic [3:0] r);
    push_exp(p, l, r);
    pattern_in = p;
    len_in = l;
    repeat_in = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_Q", Q, 1);
    chk("start_busy", busy, 1);
  endtask

  task automatic step_bit(input bit last);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("xv_latency", x_valid, 1);
    chk("done_at_last", done, last);
    chk("Q_step", Q, last ? 2 : 1);
    @(negedge clk);
    chk("xv_pulse", x_valid, 0);
    chk("x_hold", x_out, last_bit);
    chk("Q_after", Q, last ? 0 : 1);
    chk("busy_after", busy, !last);
    chk("done_pulse", done, 0);
  endtask

  task automatic run(input logic [5:0] p, input logic [2:0] l,
                     input logic [3:0] r, input int n);
    int base;
    base = done_cnt;
    start_pat(p, l, r);
    for (int i = 0; i < n; i++) step_bit(i == n - 1);
    chk("sb_drained", q.size(), 0);
    chk("done_count", done_cnt - base, 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    step = 1'b0;
    pattern_in = '0;
    len_in = '0;
    repeat_in = '0;
    @(negedge clk);
    chk("rst_x_out", x_out, 0);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_Q", Q, 0);
    reset = 1'b0;
    @(negedge clk);

    // single pass and back-to-back repeat
    run(6'b101011, 3'd6, 4'd1, 6);
    run(6'b101011, 3'd6, 4'd2, 12);

    // length clamping and zero repeat
    run(6'b110000, 3'd0, 4'd0, 6);
    run(6'b110000, 3'd7, 4'd1, 6);
    run(6'b001101, 3'd3, 4'd3, 9);

    // start with step in IDLE, then start during SEND
    d0 = done_cnt;
    push_exp(6'b101011, 3'd6, 4'd1);
    pattern_in = 6'b101011;
    len_in = 3'd6;
    repeat_in = 4'd1;
    start = 1'b1;
    step = 1'b1;
    @(negedge clk);
    start = 1'b0;
    step = 1'b0;
    chk("ss_no_xv", x_valid, 0);
    chk("ss_Q", Q, 1);
    step_bit(1'b0);
    step_bit(1'b0);
    pattern_in = 6'b000000;
    len_in = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("send_start_Q", Q, 1);
    chk("send_start_xv", x_valid, 0);
    for (int i = 0; i < 4; i++) step_bit(i == 3);
    chk("ss_drained", q.size(), 0);
    chk("ss_done", done_cnt - d0, 1);

    // abort after bit 3
    d0 = done_cnt;
    start_pat(6'b101011, 3'd6, 4'd1);
    for (int i = 0; i < 3; i++) step_bit(1'b0);
    abort = 1'b1;
    step = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    step = 1'b0;
    q.delete();
    chk("ab_Q", Q, 0);
    chk("ab_busy", busy, 0);
    chk("ab_xv", x_valid, 0);
    chk("ab_x_out", x_out, 1);
    chk("ab_done", done, 0);
    @(negedge clk);
    chk("ab_x_hold", x_out, 1);
    chk("ab_no_done", done_cnt - d0, 0);
    run(6'b101011, 3'd6, 4'd1, 6);

    // asynchronous reset mid-transfer
    d0 = done_cnt;
    start_pat(6'b101011, 3'd6, 4'd1);
    for (int i = 0; i < 3; i++) step_bit(1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_x_out", x_out, 0);
    chk("ar_Q", Q, 0);
    chk("ar_busy", busy, 0);
    chk("ar_xv", x_valid, 0);
    chk("ar_done", done, 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      chk("ar_step_xv", x_valid, 0);
      @(negedge clk);
      chk("ar_step_Q", Q, 0);
    end
    chk("ar_no_done", done_cnt - d0, 0);
    run(6'b011010, 3'd5, 4'd2, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
